keypad_decoder: RTL and testbench

Scans a 4-row x 5-column calculator keypad and debounces the key presses. It turns each debounced press into a single-cycle command pulse, which feeds the calculator control FSM directly as dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in and MC_in. It also supplies the digit value and operator code that the operand and operator registers latch on those pulses. Each physical press yields exactly one event: no auto-repeat, and chords are rejected.

---
 rtl/calc_pkg.sv | 122 ++++++++++++
 rtl/keypad_decoder_if.sv | 36 +++
 rtl/keypad_scan.sv | 113 +++++++++++
 rtl/keypad_decoder.sv | 130 +++++++++++++
 tb/tb_keypad_decoder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end.
//   - keypad geometry (NUM_ROWS x NUM_COLS)
//   - key codes, where code = row*NUM_COLS + col
//   - operator codes latched by the operator register
//   - frame classification, debounce state and command-pulse bundle types
//   - decode helpers from a key code to command pulses, digit value and op code
package calc_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 5;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [4:0] key_code_t;

    // row 0
    localparam key_code_t KEY_1    = 5'd0;
    localparam key_code_t KEY_2    = 5'd1;
    localparam key_code_t KEY_3    = 5'd2;
    localparam key_code_t KEY_ADD  = 5'd3;
    localparam key_code_t KEY_BKSP = 5'd4;
    // row 1
    localparam key_code_t KEY_4    = 5'd5;
    localparam key_code_t KEY_5    = 5'd6;
    localparam key_code_t KEY_6    = 5'd7;
    localparam key_code_t KEY_SUB  = 5'd8;
    localparam key_code_t KEY_CLR  = 5'd9;
    // row 2
    localparam key_code_t KEY_7    = 5'd10;
    localparam key_code_t KEY_8    = 5'd11;
    localparam key_code_t KEY_9    = 5'd12;
    localparam key_code_t KEY_MUL  = 5'd13;
    localparam key_code_t KEY_MS   = 5'd14;
    // row 3
    localparam key_code_t KEY_0    = 5'd15;
    localparam key_code_t KEY_EQ   = 5'd16;
    localparam key_code_t KEY_DIV  = 5'd17;
    localparam key_code_t KEY_MR   = 5'd18;
    localparam key_code_t KEY_MC   = 5'd19;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_cls_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        EMIT      = 2'd2,
        HOLD      = 2'd3
    } deb_state_t;

    typedef struct packed {
        logic dig;
        logic op;
        logic sub;
        logic ex;
        logic bksp;
        logic clr;
        logic ms;
        logic mr;
        logic mc;
    } cmd_t;

    // '-' raises both sub and op; the control FSM decides between
    // negation and subtraction from its own state.
    function automatic cmd_t key_cmd(key_code_t k);
        cmd_t c;
        c = '0;
        case (k)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: c.dig  = 1'b1;
            KEY_ADD, KEY_MUL, KEY_DIV:         c.op   = 1'b1;
            KEY_SUB: begin
                c.op  = 1'b1;
                c.sub = 1'b1;
            end
            KEY_EQ:                            c.ex   = 1'b1;
            KEY_BKSP:                          c.bksp = 1'b1;
            KEY_CLR:                           c.clr  = 1'b1;
            KEY_MS:                            c.ms   = 1'b1;
            KEY_MR:                            c.mr   = 1'b1;
            KEY_MC:                            c.mc   = 1'b1;
            default:                           c      = '0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] key_digit(key_code_t k);
        logic [3:0] d;
        case (k)
            KEY_1:   d = 4'd1;
            KEY_2:   d = 4'd2;
            KEY_3:   d = 4'd3;
            KEY_4:   d = 4'd4;
            KEY_5:   d = 4'd5;
            KEY_6:   d = 4'd6;
            KEY_7:   d = 4'd7;
            KEY_8:   d = 4'd8;
            KEY_9:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] key_op(key_code_t k);
        logic [1:0] o;
        case (k)
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            KEY_DIV: o = OP_DIV;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Keypad pins plus the command bus toward the calculator control FSM.
//   row_n   : keypad rows, active-low (keypad -> decoder)
//   col_n   : one-hot active-low column drive (decoder -> keypad)
//   *_in    : one-cycle command pulses
//   digit   : digit value, valid with dig_in, held afterwards
//   op_code : operator code, valid with op_in, held afterwards
// master = the decoder, slave = keypad/consumer side.
interface keypad_decoder_if;

    logic [3:0] row_n;
    logic [4:0] col_n;
    logic       dig_in;
    logic [3:0] digit;
    logic       op_in;
    logic [1:0] op_code;
    logic       sub_in;
    logic       ex_in;
    logic       bksp_in;
    logic       reset_in;
    logic       MS_in;
    logic       MR_in;
    logic       MC_in;

    modport master (
        input  row_n,
        output col_n, dig_in, digit, op_in, op_code, sub_in, ex_in,
               bksp_in, reset_in, MS_in, MR_in, MC_in
    );

    modport slave (
        output row_n,
        input  col_n, dig_in, digit, op_in, op_code, sub_in, ex_in,
               bksp_in, reset_in, MS_in, MR_in, MC_in
    );

endinterface

// File: rtl/keypad_scan.sv
// Column scanner and frame encoder.
//   clock, reset_n : clock, async active-low reset
//   row_n          : raw keypad rows (asynchronous), synchronised here
//   col_n          : registered one-hot active-low column drive
//   frame_valid    : high on the sample cycle of the last column
//   key_code       : code of the (first) key seen in the frame
//   frame_cls      : NONE / ONE / MULTI for the frame closing this cycle
// Each column is driven for SCAN_DIV cycles; the rows are sampled on the
// last cycle of the dwell so the synchroniser has long settled.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic                frame_valid,
    output key_code_t           key_code,
    output frame_cls_t          frame_cls
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(NUM_ROWS);

    logic [DW-1:0]       dwell;
    logic [2:0]          col_idx;
    logic [2:0]          col_nxt;
    logic                sample;
    logic                last_col;
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;

    // Accumulated result of the columns already sampled in this frame.
    logic                acc_any;
    logic                acc_multi;
    key_code_t           acc_code;

    logic [RW:0]         col_cnt;
    logic [RW-1:0]       col_row;
    key_code_t           col_code;
    logic                cur_any;
    logic                cur_multi;
    key_code_t           cur_code;

    assign sample   = (dwell == DW'(SCAN_DIV - 1));
    assign last_col = (col_idx == 3'(NUM_COLS - 1));
    assign col_nxt  = last_col ? 3'd0 : col_idx + 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dwell   <= '0;
            col_idx <= '0;
            col_n   <= ~NUM_COLS'(1);
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_nxt;
            col_n   <= ~(NUM_COLS'(1) << col_nxt);
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    // Merge the current column's rows into the running frame result.
    always_comb begin
        col_cnt = '0;
        col_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync[r]) begin
                col_cnt = col_cnt + 1'b1;
                col_row = RW'(r);
            end
        end
        col_code  = key_code_t'(int'(col_row) * NUM_COLS + int'(col_idx));
        cur_any   = acc_any | (col_cnt != '0);
        cur_multi = acc_multi | (col_cnt > (RW+1)'(1)) | (acc_any & (col_cnt != '0));
        cur_code  = acc_any ? acc_code : col_code;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (sample) begin
            if (last_col) begin
                acc_any   <= 1'b0;
                acc_multi <= 1'b0;
                acc_code  <= '0;
            end else begin
                acc_any   <= cur_any;
                acc_multi <= cur_multi;
                acc_code  <= cur_code;
            end
        end
    end

    assign frame_valid = sample & last_col;
    assign key_code    = cur_code;
    assign frame_cls   = cur_multi ? FR_MULTI : (cur_any ? FR_ONE : FR_NONE);

endmodule

// File: rtl/keypad_decoder.sv
// Calculator keypad decoder: scan, debounce and single-shot command pulses.
//   clock, reset_n : clock, async active-low reset
//   kp (master)    : row_n in; col_n, command pulses, digit, op_code out
// A key must be the only key seen for DEBOUNCE_SCANS consecutive frames to
// fire once; a further press of anything needs DEBOUNCE_SCANS consecutive
// empty frames first. Chords never fire.
module keypad_decoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 100
) (
    input  logic     clock,
    input  logic     reset_n,
    keypad_decoder_if.master kp
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [NUM_COLS-1:0] col_n;
    logic                frame_valid;
    key_code_t           key_code;
    frame_cls_t          frame_cls;

    deb_state_t          state;
    logic [CW-1:0]       cnt;
    key_code_t           cand;
    cmd_t                cmd;
    logic [3:0]          digit_r;
    logic [1:0]          op_r;

    logic                one_frame;
    logic                go;

    keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clock       (clock),
        .reset_n     (reset_n),
        .row_n       (kp.row_n),
        .col_n       (col_n),
        .frame_valid (frame_valid),
        .key_code    (key_code),
        .frame_cls   (frame_cls)
    );

    assign one_frame = frame_valid & (frame_cls == FR_ONE);

    // Accept on the frame that completes the run. With a single-frame
    // debounce the first ONE frame seen from IDLE already completes it.
    assign go = ((state == IDLE) && (DEBOUNCE_SCANS == 1) && one_frame) ||
                ((state == DEB_PRESS) && one_frame && (key_code == cand) &&
                 (cnt == CW'(DEBOUNCE_SCANS - 1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cand    <= '0;
            cmd     <= '0;
            digit_r <= '0;
            op_r    <= OP_ADD;
        end else begin
            cmd <= '0;
            if (go) begin
                // Pulses and the latched values become visible in the EMIT cycle.
                cmd   <= key_cmd(key_code);
                cand  <= key_code;
                cnt   <= '0;
                state <= EMIT;
                if (key_cmd(key_code).dig) digit_r <= key_digit(key_code);
                if (key_cmd(key_code).op)  op_r    <= key_op(key_code);
            end else begin
                case (state)
                    IDLE: begin
                        if (one_frame) begin
                            cand  <= key_code;
                            cnt   <= CW'(1);
                            state <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (frame_valid) begin
                            if (one_frame && (key_code == cand)) begin
                                cnt <= cnt + 1'b1;
                            end else begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                    EMIT: begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                    HOLD: begin
                        if (frame_valid) begin
                            if (frame_cls == FR_NONE) begin
                                if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                    cnt   <= '0;
                                    state <= IDLE;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign kp.col_n    = col_n;
    assign kp.dig_in   = cmd.dig;
    assign kp.op_in    = cmd.op;
    assign kp.sub_in   = cmd.sub;
    assign kp.ex_in    = cmd.ex;
    assign kp.bksp_in  = cmd.bksp;
    assign kp.reset_in = cmd.clr;
    assign kp.MS_in    = cmd.ms;
    assign kp.MR_in    = cmd.mr;
    assign kp.MC_in    = cmd.mc;
    assign kp.digit    = digit_r;
    assign kp.op_code  = op_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder with SCAN_DIV=4, DEBOUNCE_SCANS=3 (20-cycle frames).
// Stimulus changes the pressed-key set only at frame boundaries, so each
// frame sees one key set. A frame-level model (runs of lone-key frames,
// re-arm after a run of empty frames) predicts the pulse in the first
// cycle of the following frame; every cycle is checked.
module tb_keypad_decoder;
    import calc_pkg::*;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = SD * NUM_COLS;

    localparam logic [8:0] P_DIG = 9'b100000000;
    localparam logic [8:0] P_OP  = 9'b010000000;
    localparam logic [8:0] P_SUB = 9'b001000000;
    localparam logic [8:0] P_EX  = 9'b000100000;
    localparam logic [8:0] P_BK  = 9'b000010000;
    localparam logic [8:0] P_CLR = 9'b000001000;
    localparam logic [8:0] P_MS  = 9'b000000100;
    localparam logic [8:0] P_MR  = 9'b000000010;
    localparam logic [8:0] P_MC  = 9'b000000001;

    typedef struct {
        int         row;
        int         col;
        logic [8:0] pulses;
        int         digit;   // -1: digit not touched
        int         op;      // -1: op_code not touched
    } vec_t;

    vec_t tbl[NUM_KEYS];

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] keys = '0;
    logic [3:0]  row_v;
    logic [8:0]  pv;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_decoder_if kp();

    keypad_decoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .kp      (kp)
    );

    always #5 clock = ~clock;

    // Passive keypad matrix: a pressed key ties its row to its column.
    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                if (keys[r*NUM_COLS+c] && !kp.col_n[c]) row_v[r] = 1'b0;
    end
    assign kp.row_n = row_v;

    assign pv = {kp.dig_in, kp.op_in, kp.sub_in, kp.ex_in, kp.bksp_in,
                 kp.reset_in, kp.MS_in, kp.MR_in, kp.MC_in};

    // Pulse monitor
    int         n_ev = 0;
    logic [8:0] last_pv = '0;
    logic [3:0] last_dig = '0;
    logic [1:0] last_op = '0;
    always @(negedge clock) begin
        if (pv != 9'b0) begin
            n_ev     <= n_ev + 1;
            last_pv  <= pv;
            last_dig <= kp.digit;
            last_op  <= kp.op_code;
        end
    end

    // Reference model state
    bit         armed;
    int         run_key, run_len, none_len;
    logic [8:0] nxt_pulse;
    int         nxt_digit, nxt_op, cur_digit, cur_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input int c, input logic [8:0] p, input int d, input int o);
        tbl[r*NUM_COLS+c] = '{r, c, p, d, o};
    endtask

    task automatic model_reset();
        armed = 1; run_key = -1; run_len = 0; none_len = 0;
        nxt_pulse = '0; nxt_digit = 0; nxt_op = 0; cur_digit = 0; cur_op = 0;
    endtask

    task automatic model_frame(input logic [19:0] k);
        int n, key;
        n = $countones(k);
        key = -1;
        for (int i = 0; i < NUM_KEYS; i++) if (k[i]) key = i;
        if (armed) begin
            if (n == 1) begin
                if (key == run_key) run_len++;
                else begin run_key = key; run_len = 1; end
                if (run_len == DB) begin
                    nxt_pulse = tbl[key].pulses;
                    if (tbl[key].digit >= 0) nxt_digit = tbl[key].digit;
                    if (tbl[key].op >= 0)    nxt_op    = tbl[key].op;
                    armed = 0; none_len = 0; run_key = -1; run_len = 0;
                end
            end else begin
                run_key = -1; run_len = 0;
            end
        end else begin
            if (n == 0) begin
                none_len++;
                if (none_len == DB) armed = 1;
            end else none_len = 0;
        end
    endtask

    // One full frame with key set k, checking every cycle.
    task automatic run_frame(input logic [19:0] k);
        logic [8:0] ep;
        logic [4:0] ec;
        keys = k;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clock);
            ep = '0;
            if (j == 0) begin
                ep = nxt_pulse;
                nxt_pulse = '0;
                cur_digit = nxt_digit;
                cur_op = nxt_op;
            end
            ec = ~(5'b00001 << (j / SD));
            chk("pulses", 32'(pv), 32'(ep));
            chk("col_n", 32'(kp.col_n), 32'(ec));
            if (j == 0) begin
                chk("digit", 32'(kp.digit), 32'(cur_digit));
                chk("op_code", 32'(kp.op_code), 32'(cur_op));
            end
        end
        model_frame(k);
        #1;
    endtask

    task automatic frames(input logic [19:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(k);
    endtask

    // Assert reset 'partial' cycles into the current frame.
    task automatic do_reset(input int partial);
        for (int j = 0; j < partial; j++) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst col_n", 32'(kp.col_n), 32'(5'b11110));
        chk("rst pulses", 32'(pv), 32'(0));
        chk("rst digit", 32'(kp.digit), 32'(0));
        chk("rst op_code", 32'(kp.op_code), 32'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int         ev0;
        logic [19:0] k, prev;
        int         a, b, r;

        add(0,0,P_DIG,1,-1); add(0,1,P_DIG,2,-1); add(0,2,P_DIG,3,-1);
        add(0,3,P_OP,-1,0);  add(0,4,P_BK,-1,-1);
        add(1,0,P_DIG,4,-1); add(1,1,P_DIG,5,-1); add(1,2,P_DIG,6,-1);
        add(1,3,P_OP|P_SUB,-1,1); add(1,4,P_CLR,-1,-1);
        add(2,0,P_DIG,7,-1); add(2,1,P_DIG,8,-1); add(2,2,P_DIG,9,-1);
        add(2,3,P_OP,-1,2);  add(2,4,P_MS,-1,-1);
        add(3,0,P_DIG,0,-1); add(3,1,P_EX,-1,-1); add(3,2,P_OP,-1,3);
        add(3,3,P_MR,-1,-1); add(3,4,P_MC,-1,-1);

        // Power-on reset
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("por col_n", 32'(kp.col_n), 32'(5'b11110));
        chk("por pulses", 32'(pv), 32'(0));
        chk("por digit", 32'(kp.digit), 32'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset mid-scan with a key held; it must fire as a fresh press.
        frames(20'(1) << KEY_7, 1);
        do_reset(7);
        ev0 = n_ev;
        frames(20'(1) << KEY_7, DB);
        frames('0, DB);
        chk("held-thru-reset count", 32'(n_ev - ev0), 32'd1);
        chk("held-thru-reset digit", 32'(last_dig), 32'd7);

        // Every key once
        for (int i = 0; i < NUM_KEYS; i++) begin
            ev0 = n_ev;
            frames(20'(1) << (tbl[i].row * NUM_COLS + tbl[i].col), DB);
            frames('0, DB);
            chk($sformatf("key%0d count", i), 32'(n_ev - ev0), 32'd1);
            chk($sformatf("key%0d pulses", i), 32'(last_pv), 32'(tbl[i].pulses));
            if (tbl[i].digit >= 0) chk($sformatf("key%0d digit", i), 32'(last_dig), 32'(tbl[i].digit));
            if (tbl[i].op >= 0)    chk($sformatf("key%0d op", i), 32'(last_op), 32'(tbl[i].op));
        end

        // Long hold: one pulse only
        ev0 = n_ev;
        frames(20'(1) << KEY_7, 30);
        frames('0, DB);
        chk("long hold count", 32'(n_ev - ev0), 32'd1);
        chk("long hold digit", 32'(last_dig), 32'd7);

        // '-' then '*'
        frames(20'(1) << KEY_SUB, DB); frames('0, DB);
        chk("minus pulses", 32'(last_pv), 32'(P_OP | P_SUB));
        chk("minus op", 32'(last_op), 32'(OP_SUB));
        frames(20'(1) << KEY_MUL, DB); frames('0, DB);
        chk("mul pulses", 32'(last_pv), 32'(P_OP));
        chk("mul op", 32'(last_op), 32'(OP_MUL));

        // Bouncing backspace, then a clean hold
        ev0 = n_ev;
        for (int i = 0; i < 5; i++) begin
            frames(20'(1) << KEY_BKSP, 1);
            frames('0, 1);
        end
        chk("bounce count", 32'(n_ev - ev0), 32'd0);
        frames(20'(1) << KEY_BKSP, DB); frames('0, DB);
        chk("bksp count", 32'(n_ev - ev0), 32'd1);
        chk("bksp pulses", 32'(last_pv), 32'(P_BK));

        // Chord, then release down to one key
        ev0 = n_ev;
        frames((20'(1) << KEY_1) | (20'(1) << KEY_5), 10);
        chk("chord count", 32'(n_ev - ev0), 32'd0);
        frames(20'(1) << KEY_1, DB); frames('0, DB);
        chk("chord release count", 32'(n_ev - ev0), 32'd1);
        chk("chord release digit", 32'(last_dig), 32'd1);

        // '=' with a one-frame release glitch, then a real release
        ev0 = n_ev;
        frames(20'(1) << KEY_EQ, DB + 1);
        frames('0, 1);
        frames(20'(1) << KEY_EQ, DB + 1);
        frames('0, 1);
        chk("eq glitch count", 32'(n_ev - ev0), 32'd1);
        frames('0, DB);
        frames(20'(1) << KEY_EQ, DB);
        frames('0, DB);
        chk("eq repress count", 32'(n_ev - ev0), 32'd2);
        chk("eq pulses", 32'(last_pv), 32'(P_EX));

        // Random frames. A direct hop between two different lone keys is
        // replaced by an empty frame: the debouncer spends the hop frame
        // returning to IDLE, which the run-based model does not describe.
        prev = '0;
        for (int f = 0; f < 150; f++) begin
            if (f > 0 && $urandom_range(0, 99) < 60) k = prev;
            else begin
                r = $urandom_range(0, 99);
                if (r < 45) k = '0;
                else if (r < 85) k = 20'(1) << $urandom_range(0, NUM_KEYS - 1);
                else begin
                    a = $urandom_range(0, NUM_KEYS - 1);
                    b = (a + 1 + $urandom_range(0, NUM_KEYS - 2)) % NUM_KEYS;
                    k = (20'(1) << a) | (20'(1) << b);
                end
            end
            if ($countones(k) == 1 && $countones(prev) == 1 && k != prev) k = '0;
            run_frame(k);
            prev = k;
        end
        frames('0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
